// File: rtl/rnn_argmax_tap_if.sv
// Snooped RNN memory write bus plus the result FIFO handshake.
// master = bus/consumer side, slave = rnn_argmax_tap.
interface rnn_argmax_tap_if;
    logic        mce;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] mdata_w;
    logic        o_valid;
    logic        o_ready;
    logic [10:0] o_t;
    logic [5:0]  o_idx;
    logic [19:0] o_max;

    modport master (
        output mce, msel, maddr, mdata_w, o_ready,
        input  o_valid, o_t, o_idx, o_max
    );

    modport slave (
        input  mce, msel, maddr, mdata_w, o_ready,
        output o_valid, o_t, o_idx, o_max
    );
endinterface

// File: rtl/rnn_argmax_tap.sv
// Snoops hidden-state writes of an RNN core and reports, per timestep, the
// index and value of the largest of the 64 hidden outputs through a 4-deep FIFO.
module rnn_argmax_tap (
    input  logic              clk,
    input  logic              reset,
    rnn_argmax_tap_if.slave   bus,
    output logic              ovf_err,
    output logic              seq_err
);
    typedef enum logic {IDLE, ACCUM} state_t;

    typedef struct packed {
        logic [10:0]        t;
        logic [5:0]         idx;
        logic signed [19:0] max;
    } result_t;

    localparam logic [2:0] HID_BANK = 3'b101;

    state_t             state, state_n;
    logic [10:0]        cur_t, cur_t_n;
    logic [5:0]         exp_h, exp_h_n;
    logic [5:0]         best_i, best_i_n;
    logic signed [19:0] best_v, best_v_n;
    logic               seq_set, push;
    result_t            push_data;

    logic               cap;
    logic [10:0]        cap_t;
    logic [5:0]         cap_h;
    logic signed [19:0] cap_v;

    assign cap   = bus.mce && (bus.msel == HID_BANK);
    assign cap_t = bus.maddr[16:6];
    assign cap_h = bus.maddr[5:0];
    assign cap_v = bus.mdata_w;

    always_comb begin
        state_n  = state;
        cur_t_n  = cur_t;
        exp_h_n  = exp_h;
        best_v_n = best_v;
        best_i_n = best_i;
        seq_set  = 1'b0;
        push     = 1'b0;
        if (cap) begin
            if (cap_h == 6'd0) begin
                // h=0 always restarts a timestep; abandoning a live one is an error
                cur_t_n  = cap_t;
                best_v_n = cap_v;
                best_i_n = 6'd0;
                exp_h_n  = 6'd1;
                state_n  = ACCUM;
                seq_set  = (state == ACCUM) && (exp_h != 6'd0);
            end else if (state == ACCUM && cap_h == exp_h && cap_t == cur_t) begin
                if (cap_v > best_v) begin
                    best_v_n = cap_v;
                    best_i_n = cap_h;
                end
                exp_h_n = exp_h + 6'd1;
                if (cap_h == 6'd63) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end
            end else begin
                seq_set = 1'b1;
                state_n = IDLE;
            end
        end
    end

    // Result includes the h=63 sample, so it is taken from the next-state values.
    assign push_data = '{t: cur_t, idx: best_i_n, max: best_v_n};

    result_t     mem [4];
    logic [1:0]  wptr, rptr;
    logic [2:0]  count;
    logic        pop, full, wr_en;

    assign full  = (count == 3'd4);
    assign pop   = (count != 3'd0) && bus.o_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cur_t   <= '0;
            exp_h   <= '0;
            best_v  <= '0;
            best_i  <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            seq_err <= 1'b0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            state  <= state_n;
            cur_t  <= cur_t_n;
            exp_h  <= exp_h_n;
            best_v <= best_v_n;
            best_i <= best_i_n;
            if (seq_set) seq_err <= 1'b1;
            if (push && !wr_en) ovf_err <= 1'b1;
            if (wr_en) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 2'd1;
            end
            if (pop) rptr <= rptr + 2'd1;
            case ({wr_en, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign bus.o_valid = (count != 3'd0);
    assign bus.o_t     = mem[rptr].t;
    assign bus.o_idx   = mem[rptr].idx;
    assign bus.o_max   = mem[rptr].max;
endmodule

// File: tb/tb_rnn_argmax_tap.sv
// Directed bench for rnn_argmax_tap: scoreboard of expected per-timestep
// argmax results, checked as results leave the FIFO.
module tb_rnn_argmax_tap;
    typedef struct packed {
        logic [10:0]        t;
        logic [5:0]         idx;
        logic signed [19:0] max;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    logic ovf_err, seq_err;
    int   checks = 0;
    int   errors = 0;
    res_t q[$];
    logic signed [19:0] vals [64];

    rnn_argmax_tap_if bif ();

    rnn_argmax_tap dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bif),
        .ovf_err (ovf_err),
        .seq_err (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input int t);
        res_t r;
        r.t   = t[10:0];
        r.idx = 6'd0;
        r.max = vals[0];
        for (int h = 1; h < 64; h++)
            if (vals[h] > r.max) begin
                r.max = vals[h];
                r.idx = h[5:0];
            end
        return r;
    endfunction

    // Compare the FIFO head with the oldest expected result (consumes it).
    task automatic check_head(input string tag);
        res_t e;
        chk({tag, "_valid"}, {31'd0, bif.o_valid}, 32'd1);
        if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk({tag, "_t"},   {21'd0, bif.o_t},   {21'd0, e.t});
            chk({tag, "_idx"}, {26'd0, bif.o_idx}, {26'd0, e.idx});
            chk({tag, "_max"}, {12'd0, bif.o_max}, {12'd0, e.max});
        end
    endtask

    task automatic pop_one(input string tag);
        check_head(tag);
        bif.o_ready = 1'b1;
        @(negedge clk);
        bif.o_ready = 1'b0;
    endtask

    task automatic noise_write();
        @(negedge clk);
        bif.mce     = 1'b1;
        bif.msel    = 3'b010;
        bif.maddr   = {$urandom_range(2047, 0), 6'd0};
        bif.mdata_w = $urandom;
    endtask

    // Drive one timestep of hidden writes; returns on the negedge after the last.
    task automatic run_ts(input int t, input int skip_h, input int stop_h,
                          input bit noise, input bit pop_last);
        for (int h = 0; h < 64; h++) begin
            if (h == skip_h) continue;
            if (stop_h >= 0 && h > stop_h) break;
            if (noise) noise_write();
            @(negedge clk);
            bif.mce     = 1'b1;
            bif.msel    = 3'b101;
            bif.maddr   = {t[10:0], h[5:0]};
            bif.mdata_w = vals[h];
            if (h == 63 && pop_last) begin
                check_head("pop_on_push");
                bif.o_ready = 1'b1;
            end
        end
        @(negedge clk);
        bif.mce     = 1'b0;
        bif.msel    = 3'b000;
        bif.o_ready = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset       = 1'b1;
        bif.mce     = 1'b1;
        bif.msel    = 3'b101;
        bif.maddr   = 17'd0;
        bif.mdata_w = 20'h12345;
        bif.o_ready = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        bif.mce     = 1'b0;
        bif.msel    = 3'b000;
        bif.o_ready = 1'b0;
        q.delete();
        chk({tag, "_valid"}, {31'd0, bif.o_valid}, 32'd0);
        chk({tag, "_ovf"},   {31'd0, ovf_err},     32'd0);
        chk({tag, "_seq"},   {31'd0, seq_err},     32'd0);
        chk({tag, "_oflds"}, {bif.o_t, bif.o_idx, bif.o_max}, 37'd0);
    endtask

    task automatic fill_random();
        for (int h = 0; h < 64; h++) vals[h] = $urandom;
    endtask

    initial begin
        res_t held;
        reset       = 1'b1;
        bif.mce     = 1'b0;
        bif.msel    = 3'b000;
        bif.maddr   = '0;
        bif.mdata_w = '0;
        bif.o_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset("rst0");

        // single peak at h=40
        for (int h = 0; h < 64; h++) vals[h] = 20'(h * 16);
        vals[40] = 20'h10000;
        run_ts(5, -1, -1, 1'b0, 1'b0);
        q.push_back(model(5));
        chk("peak_idx_const", {26'd0, bif.o_idx}, 32'd40);
        chk("peak_max_const", {12'd0, bif.o_max}, 32'h10000);
        pop_one("peak");
        chk("peak_empty", {31'd0, bif.o_valid}, 32'd0);

        // all equal: lowest index wins; also t=2047 then t=0
        for (int h = 0; h < 64; h++) vals[h] = 20'hF0000;
        run_ts(2047, -1, -1, 1'b0, 1'b0);
        q.push_back(model(2047));
        pop_one("all_eq");
        for (int h = 0; h < 64; h++) vals[h] = 20'hF0000 - 20'(h);
        vals[10] = 20'h08000;
        vals[20] = 20'h08000;
        run_ts(0, -1, -1, 1'b0, 1'b0);
        q.push_back(model(0));
        chk("tie_idx_const", {26'd0, bif.o_idx}, 32'd10);
        pop_one("tie");

        // overflow: five timesteps with no consumer
        for (int t = 0; t < 5; t++) begin
            fill_random();
            run_ts(t, -1, -1, 1'b0, 1'b0);
            if (t < 4) q.push_back(model(t));
        end
        chk("ovf_set", {31'd0, ovf_err}, 32'd1);
        held = q[0];
        repeat (2) @(negedge clk);
        chk("hold_t",   {21'd0, bif.o_t},   {21'd0, held.t});
        chk("hold_max", {12'd0, bif.o_max}, {12'd0, held.max});
        for (int i = 0; i < 4; i++) pop_one("ovf_drain");
        chk("ovf_empty", {31'd0, bif.o_valid}, 32'd0);
        bif.o_ready = 1'b1;
        repeat (2) @(negedge clk);
        bif.o_ready = 1'b0;
        chk("ready_when_empty", {31'd0, bif.o_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);

        // full FIFO, push coincides with pop
        do_reset("rst1");
        for (int t = 0; t < 4; t++) begin
            fill_random();
            run_ts(t, -1, -1, 1'b0, 1'b0);
            q.push_back(model(t));
        end
        fill_random();
        run_ts(9, -1, -1, 1'b0, 1'b1);
        q.push_back(model(9));
        chk("full_pp_ovf", {31'd0, ovf_err}, 32'd0);
        for (int i = 0; i < 4; i++) pop_one("full_pp_drain");
        chk("full_pp_empty", {31'd0, bif.o_valid}, 32'd0);

        // skipped index -> sequence error, no result; next clean run delivered
        fill_random();
        run_ts(2, 17, -1, 1'b0, 1'b0);
        chk("skip_seq", {31'd0, seq_err}, 32'd1);
        chk("skip_no_result", {31'd0, bif.o_valid}, 32'd0);
        fill_random();
        run_ts(3, -1, -1, 1'b0, 1'b0);
        q.push_back(model(3));
        pop_one("after_skip");
        chk("after_skip_empty", {31'd0, bif.o_valid}, 32'd0);

        // reset mid-timestep, other-bank writes interleaved
        do_reset("rst2");
        fill_random();
        run_ts(7, -1, 30, 1'b1, 1'b0);
        do_reset("rst_mid");
        fill_random();
        run_ts(8, -1, -1, 1'b1, 1'b0);
        q.push_back(model(8));
        pop_one("after_rst");
        chk("after_rst_seq", {31'd0, seq_err}, 32'd0);
        chk("after_rst_empty", {31'd0, bif.o_valid}, 32'd0);
        chk("sb_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rnn_argmax_tap.md
RNN_ARGMAX_TAP -- requirements
Module: rnn_argmax_tap

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: mce  input  1  memory chip enable, snooped from the RNN core.
REQ-004 SHALL have port: msel  input  3  memory bank select, snooped; 3'b101 is the hidden-state output bank.
REQ-005 SHALL have port: maddr  input  17  write address, snooped; maddr[16:6] is timestep t, maddr[5:0] is hidden index h.
REQ-006 SHALL have port: mdata_w  input  20  write data, snooped; signed Q4.16 hidden value.
REQ-007 SHALL have port: o_valid  output  1  result available at FIFO head.
REQ-008 SHALL have port: o_ready  input  1  consumer accepts the head result.
REQ-009 SHALL have port: o_t  output  11  timestep of the head result.
REQ-010 SHALL have port: o_idx  output  6  argmax hidden index of the head result.
REQ-011 SHALL have port: o_max  output  20  signed maximum value of the head result.
REQ-012 SHALL have port: ovf_err  output  1  sticky flag: a result was dropped because the FIFO was full.
REQ-013 SHALL have port: seq_err  output  1  sticky flag: an out-of-order write was seen.

Function
REQ-014 A capture SHALL occur on a rising edge with mce=1 and msel=3'b101; all other bus cycles SHALL be ignored.
REQ-015 The FSM SHALL have two states, IDLE and ACCUM, plus registers cur_t(11), exp_h(6), best_v(20, signed) and best_i(6).
REQ-016 A capture with h=0 in either state SHALL load cur_t=t, best_v=mdata_w, best_i=0 and exp_h=1, and SHALL enter ACCUM; if the FSM was in ACCUM with exp_h!=0, seq_err SHALL also be set.
REQ-017 A capture in ACCUM with h=exp_h and t=cur_t SHALL set best_v and best_i to the new value and h when mdata_w > best_v (signed, strict), and SHALL increment exp_h; on a tie the lower index SHALL be kept.
REQ-018 A capture in ACCUM with h!=0 and (h!=exp_h or t!=cur_t) SHALL set seq_err, discard the partial result and enter IDLE.
REQ-019 A capture in IDLE with h!=0 SHALL set seq_err and SHALL leave the FSM in IDLE.
REQ-020 The in-order capture with h=63 SHALL push {cur_t, final best_i, final best_v} into the FIFO on the same edge, using the comparison result that includes the h=63 sample, and the FSM SHALL enter IDLE.
REQ-021 The output SHALL be a 4-entry FIFO; o_valid SHALL equal "not empty"; o_t, o_idx and o_max SHALL present the head entry and SHALL hold stable while o_valid=1 and o_ready=0.
REQ-022 Latency: o_valid SHALL be 1 in the cycle after the h=63 capture edge when the FIFO was empty.
REQ-023 A pop SHALL occur on an edge with o_valid=1 and o_ready=1; o_ready SHALL be ignored when empty.
REQ-024 A push while full without a simultaneous pop SHALL drop the new result and set ovf_err; a push while full with a simultaneous pop SHALL succeed and the count SHALL stay 4.
REQ-025 A simultaneous push and pop at any occupancy SHALL leave the count unchanged and preserve order.
REQ-026 Read and write pointers SHALL be 2 bits and wrap modulo 4; a separate 3-bit count SHALL distinguish full from empty.
REQ-027 The block SHALL place no ordering constraint on t across timesteps, so t may wrap from 2047 to 0.

Reset
REQ-028 While reset=1 at a rising edge the FSM SHALL enter IDLE, the FIFO SHALL empty, and o_valid, ovf_err and seq_err SHALL be 0; best_v, best_i, cur_t, exp_h, o_t, o_idx and o_max SHALL be 0.
REQ-029 Reset SHALL take priority over a capture or pop on the same edge, and reset mid-timestep SHALL discard the partial result without setting seq_err.
REQ-030 ovf_err and seq_err SHALL clear only on reset.

Verification
REQ-031 t=5, h=0..63 with value=h*16, except h=40 -> 20'h10000 -> one cycle later o_valid=1, o_t=5, o_idx=40, o_max=20'h10000.
REQ-032 All 64 values = 20'hF0000 (-1.0) -> o_idx=0, o_max=20'hF0000; h=10 and h=20 both 20'h08000 with all others negative -> o_idx=10.
REQ-033 o_ready=0, five full timesteps t=0..4 -> results t=0..3 retained, ovf_err=1; then o_ready=1 -> results pop in order 0,1,2,3, then o_valid=0.
REQ-034 FIFO full with o_ready=1 on the same edge as the h=63 push of t=9 -> no drop, ovf_err=0, t=9 becomes the last entry.
REQ-035 t=2 run with h=17 skipped -> seq_err=1 and no result for t=2; a following clean t=3 run -> result t=3 delivered.
REQ-036 reset asserted after h=30 of t=7, then a clean t=8 run -> only t=8 delivered, seq_err=0; msel=3'b010 writes interleaved throughout -> no effect.
